mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, the data-address width.
REQ-002 SHALL have ports `clk` (in, 1, clock) and `rst` (in, 1, reset). There is one clock; reset is asynchronous and active-high.
REQ-003 SHALL have input ports from the execute stage:
- ex_valid, 1: an instruction is present.
- ex_op, 4 (mem_op_t): NONE/LB/LH/LW/LBU/LHU/SB/SH/SW.
- ex_addr, ADDR_W: ALU result, used as the address.
- ex_wdata, 32: store data (rs2).
- ex_rd_addr, 5: destination register.
- ex_wb_en, 1: register write requested.
REQ-004 SHALL have output `stall` (1): holds the execute stage and all upstream stages.
REQ-005 SHALL have the data-memory port:
- dmem_req out 1, dmem_we out 1.
- dmem_addr out ADDR_W (word-aligned, [1:0]=0).
- dmem_wdata out 32, dmem_be out 4.
- dmem_ack in 1, dmem_rdata in 32.
REQ-006 SHALL have outputs to writeback: wb_valid 1, wb_en 1, wb_rd_addr 5, wb_data 32, misaligned 1.

Function
REQ-007 SHALL implement a two-state FSM, IDLE and WAIT.
REQ-008 `stall` SHALL be combinational: (state==WAIT) && !dmem_ack. Accept = ex_valid && !stall.
REQ-009 On accept of an op of NONE, SHALL register wb_valid=1, wb_data=ex_addr, wb_en=ex_wb_en, and wb_rd_addr at the next edge (1-cycle latency).
REQ-010 On accept of an aligned load or store, SHALL latch op, address, wdata and rd, then go to WAIT.
REQ-011 In that same accepting cycle, SHALL drive wb_valid=0 at the next edge.
REQ-012 In WAIT, SHALL hold dmem_req=1 and keep dmem_addr/we/be/wdata stable until dmem_ack.
REQ-013 In any state other than WAIT, dmem_req SHALL be 0.
REQ-014 On dmem_ack in WAIT, at the next edge SHALL:
- register the completed op's result with wb_valid=1;
- return to IDLE, or remain in WAIT if a new memory op is accepted in the same cycle.
REQ-015 An ack in the first WAIT cycle SHALL be legal, giving a load/store latency of 2 edges from accept. Each additional wait cycle SHALL add 1.
REQ-016 SHALL ignore dmem_ack in IDLE.
REQ-017 Store byte enables and data SHALL be:
- SB: be=0001<<addr[1:0], wdata={4{byte}}.
- SH: be=0011<<(2*addr[1]), wdata={2{half}}.
- SW: be=1111.
REQ-018 Loads SHALL select the lane by the latched addr[1:0]. LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend; LW SHALL pass through unchanged.
REQ-019 Stores SHALL produce wb_valid=1 with wb_en=0.
REQ-020 wb_en SHALL be forced to 0 when rd_addr==0.
REQ-021 Misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) SHALL:
- issue no memory request and not enter WAIT;
- at the next edge produce misaligned=1 for exactly one cycle, wb_valid=1 and wb_en=0.
REQ-022 When ex_valid=0 at a non-stalled edge, SHALL register wb_valid=0 and misaligned=0.
REQ-023 wb_* outputs SHALL hold their values while stall=1.

Reset
REQ-024 On rst, asynchronously and immediately, SHALL force state=IDLE and set to 0: dmem_req, dmem_we, dmem_be, wb_valid, wb_en, misaligned, wb_data, wb_rd_addr.
REQ-025 Reset during WAIT SHALL abandon the access. A later ack SHALL be ignored per REQ-016.

Structure
REQ-026 Package mem_pkg SHALL hold the mem_op_t enum and the FSM state enum.
REQ-027 Combinational sub-module load_align SHALL perform lane select and extension (inputs rdata, addr[1:0], op; output 32-bit).

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- NONE, addr=0x1234, rd=5, wb_en=1 -> next edge: wb_valid=1, wb_data=0x1234, stall never high.
- SB addr=0x103 wdata=0xAB, ack after 3 wait cycles -> be=1000, wdata=0xABABABAB, dmem_addr=0x100, stall high 3 cycles, wb_en=0.
- LB addr=0x102, rdata=0x00800000, ack in first cycle -> wb_data=0xFFFFFF80; the same sequence with LBU -> 0x00000080.
- LW addr=0x106 -> no dmem_req, misaligned=1 for one cycle, wb_en=0.
- LW then back-to-back SW, ack in first cycle each -> second op accepted on the ack cycle, dmem_req continuous, results in order.
- rst asserted mid-WAIT -> dmem_req=0 immediately; late ack ignored; next NONE completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the memory stage: operation encoding, FSM states,
// writeback payload and small decode helpers.
package mem_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [OP_W-1:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LBU  = 4'd4,
        MEM_LHU  = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // One writeback result as presented to the writeback stage.
    typedef struct packed {
        logic            en;
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] data;
        logic            misaligned;
    } wb_res_t;

    function automatic logic is_load(input mem_op_t op);
        return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    endfunction

    function automatic logic is_store(input mem_op_t op);
        return op inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

    // Halfwords need addr[0]==0, words need addr[1:0]==0.
    function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] lane);
        logic mis;
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: mis = lane[0];
            MEM_LW, MEM_SW:          mis = |lane;
            default:                 mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load lane select and extension.
// Ports: rdata_i  - raw 32-bit word from data memory
//        addr_i   - byte offset of the access within the word
//        op_i     - mem_op_t encoding of the load
//        data_o   - aligned, sign/zero-extended load result
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [3:0]  op_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;
    mem_op_t     op;

    // Bring the addressed byte/halfword down to bit 0.
    assign shifted = rdata_i >> {addr_i, 3'b000};
    assign op      = mem_op_t'(op_i);

    always_comb begin
        data_o = rdata_i;
        case (op)
            MEM_LB:  data_o = {{24{shifted[7]}}, shifted[7:0]};
            MEM_LBU: data_o = {24'd0, shifted[7:0]};
            MEM_LH:  data_o = {{16{shifted[15]}}, shifted[15:0]};
            MEM_LHU: data_o = {16'd0, shifted[15:0]};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues loads/stores to a request/ack data memory,
// aligns load data and hands results to writeback in program order.
// Ports: clk, rst                 - clock, async active-high reset
//        ex_*                     - instruction from execute (valid/op/addr/wdata/rd/wb_en)
//        stall                    - combinational hold of execute and upstream
//        dmem_*                   - data memory request/ack port (word-aligned address)
//        wb_valid/wb_en/wb_rd_addr/wb_data/misaligned - registered writeback result
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [3:0]        ex_op,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [31:0]       ex_wdata,
    input  logic [4:0]        ex_rd_addr,
    input  logic              ex_wb_en,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              wb_valid,
    output logic              wb_en,
    output logic [4:0]        wb_rd_addr,
    output logic [31:0]       wb_data,
    output logic              misaligned
);

    state_t              state_q, state_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    mem_op_t             op_q, op_d;
    logic [1:0]          lane_q, lane_d;
    logic [RD_W-1:0]     rd_q, rd_d;
    logic                wben_q, wben_d;
    logic                wb_valid_q, wb_valid_d;
    wb_res_t             wb_q, wb_d;
    logic                defer_v_q, defer_v_d;
    wb_res_t             defer_q, defer_d;

    mem_op_t             ex_op_e;
    logic                accept;
    logic                ex_mis;
    logic                ex_mem;
    logic                ex_st;
    logic                imm_v;
    logic                slot_busy;
    logic [BE_W-1:0]     st_be;
    logic [31:0]         st_wdata;
    logic [31:0]         load_data;
    wb_res_t             imm_res;
    wb_res_t             done_res;

    assign stall   = (state_q == ST_WAIT) && !dmem_ack;
    assign accept  = ex_valid && !stall;
    assign ex_op_e = mem_op_t'(ex_op);
    assign ex_mis  = is_misaligned(ex_op_e, ex_addr[1:0]);
    assign ex_st   = is_store(ex_op_e);
    assign ex_mem  = (is_load(ex_op_e) || ex_st) && !ex_mis;
    // Accepted ops that finish without touching memory (NONE, misaligned).
    assign imm_v   = accept && !ex_mem;
    // The writeback slot at the coming edge is already claimed by an older op.
    assign slot_busy = (state_q == ST_WAIT) || defer_v_q;

    load_align u_load_align (
        .rdata_i (dmem_rdata),
        .addr_i  (lane_q),
        .op_i    (op_q),
        .data_o  (load_data)
    );

    // Store lane enables and replicated store data.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = ex_wdata;
        case (ex_op_e)
            MEM_SB: begin
                st_be    = 4'b0001 << ex_addr[1:0];
                st_wdata = {4{ex_wdata[7:0]}};
            end
            MEM_SH: begin
                st_be    = 4'b0011 << {ex_addr[1], 1'b0};
                st_wdata = {2{ex_wdata[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = ex_wdata;
            end
        endcase
    end

    // Results for an op finishing now: immediate (execute side) or completed access.
    always_comb begin
        imm_res            = '0;
        imm_res.misaligned = ex_mis;
        imm_res.en         = !ex_mis && ex_wb_en && (ex_rd_addr != 5'd0);
        imm_res.rd         = ex_rd_addr;
        imm_res.data       = 32'(ex_addr);

        done_res            = '0;
        done_res.en         = is_load(op_q) && wben_q && (rd_q != 5'd0);
        done_res.rd         = rd_q;
        done_res.data       = is_load(op_q) ? load_data : 32'd0;
        done_res.misaligned = 1'b0;
    end

    // Next-state and output logic; nothing moves while stalled.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        op_d       = op_q;
        lane_d     = lane_q;
        rd_d       = rd_q;
        wben_d     = wben_q;
        wb_valid_d = wb_valid_q;
        wb_d       = wb_q;
        defer_v_d  = defer_v_q;
        defer_d    = defer_q;

        if (!stall) begin
            // Oldest result wins the writeback slot: completed access, then deferred, then new.
            if (state_q == ST_WAIT) begin
                wb_valid_d = 1'b1;
                wb_d       = done_res;
            end else if (defer_v_q) begin
                wb_valid_d = 1'b1;
                wb_d       = defer_q;
            end else if (imm_v) begin
                wb_valid_d = 1'b1;
                wb_d       = imm_res;
            end else begin
                wb_valid_d    = 1'b0;
                wb_d.en       = 1'b0;
                wb_d.misaligned = 1'b0;
            end

            // A non-memory op that lost the slot is parked for one edge to keep order.
            defer_v_d = imm_v && slot_busy;
            if (imm_v && slot_busy) begin
                defer_d = imm_res;
            end

            if (accept && ex_mem) begin
                state_d = ST_WAIT;
                req_d   = 1'b1;
                we_d    = ex_st;
                addr_d  = {ex_addr[ADDR_W-1:2], 2'b00};
                wdata_d = st_wdata;
                be_d    = ex_st ? st_be : 4'b1111;
                op_d    = ex_op_e;
                lane_d  = ex_addr[1:0];
                rd_d    = ex_rd_addr;
                wben_d  = ex_wb_en;
            end else begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            op_q       <= MEM_NONE;
            lane_q     <= '0;
            rd_q       <= '0;
            wben_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_q       <= '0;
            defer_v_q  <= 1'b0;
            defer_q    <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            op_q       <= op_d;
            lane_q     <= lane_d;
            rd_q       <= rd_d;
            wben_q     <= wben_d;
            wb_valid_q <= wb_valid_d;
            wb_q       <= wb_d;
            defer_v_q  <= defer_v_d;
            defer_q    <= defer_d;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;
    assign wb_valid   = wb_valid_q;
    assign wb_en      = wb_q.en;
    assign wb_rd_addr = wb_q.rd;
    assign wb_data    = wb_q.data;
    assign misaligned = wb_q.misaligned;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios with exact timing, then random
// traffic checked against an in-order transaction model.
module tb_mem_stage;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [3:0]  ex_op;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_rd_addr;
    logic        ex_wb_en;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_en;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_data;
    logic        misaligned;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        wben;
    } txn_t;

    txn_t        expq[$];
    txn_t        reqq[$];
    logic [31:0] rdq[$];
    logic        pending    = 1'b0;
    logic        prev_stall = 1'b0;
    logic        last_wb_valid = 1'b0;
    logic [31:0] last_wb_data  = 32'd0;

    mem_stage #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_op      (ex_op),
        .ex_addr    (ex_addr),
        .ex_wdata   (ex_wdata),
        .ex_rd_addr (ex_rd_addr),
        .ex_wb_en   (ex_wb_en),
        .stall      (stall),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .wb_valid   (wb_valid),
        .wb_en      (wb_en),
        .wb_rd_addr (wb_rd_addr),
        .wb_data    (wb_data),
        .misaligned (misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rd, input logic we);
        ex_valid = 1'b1; ex_op = op; ex_addr = a; ex_wdata = wd; ex_rd_addr = rd; ex_wb_en = we;
    endtask

    // Reference rules, written from the architectural definition of each op.
    function automatic logic m_load(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd5);
    endfunction

    function automatic logic m_store(input logic [3:0] op);
        return (op >= 4'd6) && (op <= 4'd8);
    endfunction

    function automatic logic m_mis(input logic [3:0] op, input logic [31:0] a);
        int sz;
        sz = (op == 4'd2 || op == 4'd5 || op == 4'd7) ? 2 :
             (op == 4'd3 || op == 4'd8) ? 4 : 1;
        return (a % sz) != 0;
    endfunction

    function automatic logic [31:0] m_loadval(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] w);
        logic [31:0] v;
        v = w >> (8 * (a % 4));
        case (op)
            4'd1:    return 32'($signed(v[7:0]));
            4'd2:    return 32'($signed(v[15:0]));
            4'd4:    return v % 256;
            4'd5:    return v % 65536;
            default: return w;
        endcase
    endfunction

    // One random cycle: respond to memory, offer an instruction, check outputs.
    task automatic rand_cycle(input bit gen);
        logic ack_now;
        logic had_req;
        logic stall_exp;
        logic acc;
        txn_t t;
        txn_t e;
        logic [31:0] r;
        logic [31:0] a;

        had_req = reqq.size() != 0;
        if (dmem_req && had_req) begin
            e = reqq[0];
            a = e.addr;
            chk("rq_addr", dmem_addr, a - (a % 4));
            chk("rq_we", 32'(dmem_we), 32'(m_store(e.op)));
            if (e.op == 4'd6) begin
                chk("rq_be_sb", 32'(dmem_be), 32'(1 << (a % 4)));
                chk("rq_wd_sb", dmem_wdata, (e.wdata % 256) * 32'h01010101);
            end else if (e.op == 4'd7) begin
                chk("rq_be_sh", 32'(dmem_be), ((a % 4) >= 2) ? 32'hC : 32'h3);
                chk("rq_wd_sh", dmem_wdata, (e.wdata % 65536) * 32'h00010001);
            end else if (e.op == 4'd8) begin
                chk("rq_be_sw", 32'(dmem_be), 32'hF);
                chk("rq_wd_sw", dmem_wdata, e.wdata);
            end
        end

        ack_now    = had_req && (gen ? ($urandom_range(0, 2) == 0) : 1'b1);
        dmem_ack   = had_req ? ack_now : ($urandom_range(0, 7) == 0);
        dmem_rdata = $urandom;
        if (ack_now) begin
            rdq.push_back(dmem_rdata);
            reqq.delete(0);
        end

        if (!pending) begin
            if (gen && $urandom_range(0, 9) < 7) begin
                drive(4'($urandom_range(0, 8)), 32'($urandom_range(0, 1023)), $urandom,
                      5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            end else begin
                ex_valid = 1'b0;
            end
        end
        #1;
        stall_exp = had_req && !ack_now;
        chk("stall", 32'(stall), 32'(stall_exp));
        acc = ex_valid && !stall_exp;
        if (acc) begin
            t.op = ex_op; t.addr = ex_addr; t.wdata = ex_wdata; t.rd = ex_rd_addr; t.wben = ex_wb_en;
            expq.push_back(t);
            if ((m_load(t.op) || m_store(t.op)) && !m_mis(t.op, t.addr)) reqq.push_back(t);
        end
        pending    = ex_valid && !acc;
        prev_stall = stall_exp;

        @(posedge clk);
        #1;
        chk("dmem_req", 32'(dmem_req), 32'(reqq.size() != 0));
        if (prev_stall) begin
            chk("wb_hold_v", 32'(wb_valid), 32'(last_wb_valid));
            chk("wb_hold_d", wb_data, last_wb_data);
        end else if (wb_valid) begin
            if (expq.size() == 0) begin
                chk("wb_unexpected", 32'(wb_valid), 32'd0);
            end else begin
                e = expq.pop_front();
                if (m_mis(e.op, e.addr)) begin
                    chk("r_mis", 32'(misaligned), 32'd1);
                    chk("r_mis_en", 32'(wb_en), 32'd0);
                end else if (!m_load(e.op) && !m_store(e.op)) begin
                    chk("r_none_mis", 32'(misaligned), 32'd0);
                    chk("r_none_en", 32'(wb_en), 32'(e.wben && e.rd != 0));
                    chk("r_none_d", wb_data, e.addr);
                    if (wb_en) chk("r_none_rd", 32'(wb_rd_addr), 32'(e.rd));
                end else if (rdq.size() == 0) begin
                    chk("r_no_ack", 32'(wb_valid), 32'd0);
                end else begin
                    r = rdq.pop_front();
                    chk("r_mem_mis", 32'(misaligned), 32'd0);
                    if (m_load(e.op)) begin
                        chk("r_ld_d", wb_data, m_loadval(e.op, e.addr, r));
                        chk("r_ld_en", 32'(wb_en), 32'(e.wben && e.rd != 0));
                        if (wb_en) chk("r_ld_rd", 32'(wb_rd_addr), 32'(e.rd));
                    end else begin
                        chk("r_st_en", 32'(wb_en), 32'd0);
                    end
                end
            end
        end
        last_wb_valid = wb_valid;
        last_wb_data  = wb_data;
    endtask

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_op = 4'd0; ex_addr = 32'd0; ex_wdata = 32'd0;
        ex_rd_addr = 5'd0; ex_wb_en = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
        step(); step();
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_en", 32'(wb_en), 32'd0);
        chk("rst_mis", 32'(misaligned), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_we", 32'(dmem_we), 32'd0);
        chk("rst_be", 32'(dmem_be), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_rd", 32'(wb_rd_addr), 32'd0);
        rst = 1'b0;
        step();

        // NONE passes the address straight to writeback.
        drive(MEM_NONE, 32'h1234, 32'd0, 5'd5, 1'b1);
        #1 chk("none_stall", 32'(stall), 32'd0);
        step();
        chk("none_valid", 32'(wb_valid), 32'd1);
        chk("none_data", wb_data, 32'h1234);
        chk("none_en", 32'(wb_en), 32'd1);
        chk("none_rd", 32'(wb_rd_addr), 32'd5);
        ex_valid = 1'b0;
        step();
        chk("idle_valid", 32'(wb_valid), 32'd0);

        // SB to lane 3 with three wait cycles.
        drive(MEM_SB, 32'h103, 32'hAB, 5'd7, 1'b1);
        step();
        ex_valid = 1'b0;
        chk("sb_wbv0", 32'(wb_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("sb_stall", 32'(stall), 32'd1);
            chk("sb_req", 32'(dmem_req), 32'd1);
            chk("sb_addr", dmem_addr, 32'h100);
            chk("sb_be", 32'(dmem_be), 32'h8);
            chk("sb_wdata", dmem_wdata, 32'hABABABAB);
            chk("sb_we", 32'(dmem_we), 32'd1);
            step();
        end
        dmem_ack = 1'b1;
        #1 chk("sb_ack_stall", 32'(stall), 32'd0);
        step();
        dmem_ack = 1'b0;
        chk("sb_wbv", 32'(wb_valid), 32'd1);
        chk("sb_wben", 32'(wb_en), 32'd0);
        chk("sb_req_off", 32'(dmem_req), 32'd0);

        // LB sign-extends, LBU zero-extends the same lane.
        for (int k = 0; k < 2; k++) begin
            drive((k == 0) ? MEM_LB : MEM_LBU, 32'h102, 32'd0, 5'd3, 1'b1);
            step();
            ex_valid = 1'b0;
            chk("lb_req", 32'(dmem_req), 32'd1);
            chk("lb_addr", dmem_addr, 32'h100);
            dmem_ack = 1'b1; dmem_rdata = 32'h00800000;
            step();
            dmem_ack = 1'b0;
            chk("lb_wbv", 32'(wb_valid), 32'd1);
            chk("lb_data", wb_data, (k == 0) ? 32'hFFFFFF80 : 32'h00000080);
            chk("lb_rd", 32'(wb_rd_addr), 32'd3);
        end

        // Misaligned LW never reaches memory.
        drive(MEM_LW, 32'h106, 32'd0, 5'd4, 1'b1);
        step();
        ex_valid = 1'b0;
        chk("mis_req", 32'(dmem_req), 32'd0);
        chk("mis_flag", 32'(misaligned), 32'd1);
        chk("mis_wbv", 32'(wb_valid), 32'd1);
        chk("mis_en", 32'(wb_en), 32'd0);
        step();
        chk("mis_clear", 32'(misaligned), 32'd0);

        // LW then SW accepted on the LW ack cycle.
        drive(MEM_LW, 32'h200, 32'd0, 5'd4, 1'b1);
        step();
        chk("bb_req1", 32'(dmem_req), 32'd1);
        drive(MEM_SW, 32'h204, 32'hDEADBEEF, 5'd0, 1'b0);
        dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
        #1 chk("bb_accept", 32'(stall), 32'd0);
        step();
        ex_valid = 1'b0;
        chk("bb_lw_v", 32'(wb_valid), 32'd1);
        chk("bb_lw_d", wb_data, 32'h12345678);
        chk("bb_lw_rd", 32'(wb_rd_addr), 32'd4);
        chk("bb_req2", 32'(dmem_req), 32'd1);
        chk("bb_sw_addr", dmem_addr, 32'h204);
        chk("bb_sw_wd", dmem_wdata, 32'hDEADBEEF);
        chk("bb_sw_be", 32'(dmem_be), 32'hF);
        step();
        dmem_ack = 1'b0;
        chk("bb_sw_v", 32'(wb_valid), 32'd1);
        chk("bb_sw_en", 32'(wb_en), 32'd0);
        chk("bb_req_off", 32'(dmem_req), 32'd0);

        // Reset in WAIT abandons the access; a late ack is ignored.
        drive(MEM_LW, 32'h300, 32'd0, 5'd6, 1'b1);
        step();
        ex_valid = 1'b0;
        step();
        chk("rw_req", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        #1 chk("rw_req_off", 32'(dmem_req), 32'd0);
        step();
        rst = 1'b0;
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("rw_late_v", 32'(wb_valid), 32'd0);
        chk("rw_late_req", 32'(dmem_req), 32'd0);
        drive(MEM_NONE, 32'h55, 32'd0, 5'd9, 1'b1);
        step();
        ex_valid = 1'b0;
        chk("rw_none_v", 32'(wb_valid), 32'd1);
        chk("rw_none_d", wb_data, 32'h55);
        step();

        // Random traffic, then drain with immediate acks.
        last_wb_valid = wb_valid;
        last_wb_data  = wb_data;
        for (int c = 0; c < 3000; c++) rand_cycle(1'b1);
        for (int c = 0; c < 40 && (expq.size() != 0 || pending); c++) rand_cycle(1'b0);
        chk("drain_empty", 32'(expq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
